// File: rtl/opd_forward_hazard_pkg.sv
// Shared constants and the per-stage writer tag used by the operand forwarder.
package opd_forward_hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    // Entry indices of the tracked post-ID stages.
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // One in-flight writer: does it write, which register, and is it a load.
    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } stg_tag_t;

endpackage

// File: rtl/opd_fwd_mux.sv
// Per-operand forwarding select: the youngest in-flight writer of rs wins.
// If that writer is a load whose data is not available yet, not_rdy is
// raised and the operand value is left at the register file data.
module opd_fwd_mux
    import opd_forward_hazard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = STG_WB + 1,
    parameter int LOAD_LAT = STG_MEM
) (
    input  stg_tag_t               tags [DEPTH],
    input  logic [REG_ADDR_W-1:0]  rs,
    input  logic [DEPTH*XLEN-1:0]  stg_data,
    input  logic [XLEN-1:0]        reg_data,
    output logic [XLEN-1:0]        opd,
    output logic                   not_rdy
);

    logic found;

    // Scan from youngest (entry 0) to oldest; the first match decides.
    always_comb begin
        opd     = reg_data;
        not_rdy = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && tags[i].vld && (tags[i].rd == rs) && (rs != '0)) begin
                found = 1'b1;
                if (tags[i].is_load && (i < LOAD_LAT)) begin
                    not_rdy = 1'b1;
                end else begin
                    opd = stg_data[i*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/opd_forward_hazard.sv
// Operand forwarder with load-use hazard detection across DEPTH post-ID
// stages. Keeps a shift pipe of writer tags that advances every cycle
// (the back end never stalls), forwards the youngest ready result to each
// ID operand and stalls ID when the youngest match is a load still in flight.
module opd_forward_hazard
    import opd_forward_hazard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = STG_WB + 1,
    // Entry index at which load data is valid; keep 1 <= LOAD_LAT < DEPTH.
    parameter int LOAD_LAT = STG_MEM,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [REG_ADDR_W-1:0]  ID_rs1,
    input  logic [REG_ADDR_W-1:0]  ID_rs2,
    input  logic                   ID_rs1_used,
    input  logic                   ID_rs2_used,
    input  logic [REG_ADDR_W-1:0]  ID_rd,
    input  logic                   ID_rd_vld,
    input  logic                   ID_is_load,
    input  logic                   ID_vld,
    input  logic [DEPTH*XLEN-1:0]  STG_x_rd,
    input  logic [XLEN-1:0]        REGS_rddata1,
    input  logic [XLEN-1:0]        REGS_rddata2,
    output logic [XLEN-1:0]        OF_x_rs1,
    output logic [XLEN-1:0]        OF_x_rs2,
    output logic                   OF_stall,
    output logic [CNT_W-1:0]       OF_stall_cnt
);

    stg_tag_t tags [DEPTH];
    stg_tag_t ins_tag;
    logic     rs1_not_rdy;
    logic     rs2_not_rdy;

    // Tag entering EX: a stalled or flushed ID instruction becomes a bubble,
    // and writes to x0 are never tracked so they can never forward.
    always_comb begin
        ins_tag.vld     = ID_vld & ~OF_stall & ~flush & ID_rd_vld & (ID_rd != '0);
        ins_tag.rd      = ID_rd;
        ins_tag.is_load = ID_is_load;
    end

    // Writer tag shift pipe; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags[i].vld <= 1'b0;
            end
        end else begin
            tags[STG_EX] <= ins_tag;
            for (int i = STG_EX + 1; i < DEPTH; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    opd_fwd_mux #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rs1 (
        .tags     (tags),
        .rs       (ID_rs1),
        .stg_data (STG_x_rd),
        .reg_data (REGS_rddata1),
        .opd      (OF_x_rs1),
        .not_rdy  (rs1_not_rdy)
    );

    opd_fwd_mux #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_rs2 (
        .tags     (tags),
        .rs       (ID_rs2),
        .stg_data (STG_x_rd),
        .reg_data (REGS_rddata2),
        .opd      (OF_x_rs2),
        .not_rdy  (rs2_not_rdy)
    );

    // Stall only for operands actually read; a flush overrides the stall.
    always_comb begin
        OF_stall = ID_vld & ~flush &
                   ((ID_rs1_used & rs1_not_rdy) | (ID_rs2_used & rs2_not_rdy));
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            OF_stall_cnt <= '0;
        end else if (OF_stall && (OF_stall_cnt != '1)) begin
            OF_stall_cnt <= OF_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_opd_forward_hazard.sv
// Directed bench for opd_forward_hazard. A history-based model (which
// instructions issued on which cycle) predicts the outputs every cycle,
// and literal expectations pin the specific scenarios.
module tb_opd_forward_hazard;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = 3;

    localparam logic [XLEN-1:0] REGS1 = 32'h1111_0001;
    localparam logic [XLEN-1:0] REGS2 = 32'h2222_0002;
    localparam logic [DEPTH*XLEN-1:0] STG_DEF = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};

    // ---------------- clock / reset / DUT ----------------
    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [4:0]            ID_rs1, ID_rs2, ID_rd;
    logic                  ID_rs1_used, ID_rs2_used, ID_rd_vld, ID_is_load, ID_vld;
    logic [DEPTH*XLEN-1:0] stg;
    logic [XLEN-1:0]       regs1, regs2;
    logic [XLEN-1:0]       of_rs1, of_rs2;
    logic                  of_stall;
    logic [CNT_W-1:0]      of_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    opd_forward_hazard #(
        .XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_rs1_used  (ID_rs1_used),
        .ID_rs2_used  (ID_rs2_used),
        .ID_rd        (ID_rd),
        .ID_rd_vld    (ID_rd_vld),
        .ID_is_load   (ID_is_load),
        .ID_vld       (ID_vld),
        .STG_x_rd     (stg),
        .REGS_rddata1 (regs1),
        .REGS_rddata2 (regs2),
        .OF_x_rs1     (of_rs1),
        .OF_x_rs2     (of_rs2),
        .OF_stall     (of_stall),
        .OF_stall_cnt (of_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Every issued register writer is remembered with the cycle it left ID.
    // Its age in cycles since then is its stage index; age >= DEPTH is retired.
    typedef struct {
        int         cyc;
        logic [4:0] rd;
        bit         ld;
    } wr_t;

    wr_t hist[$];     // youngest at front
    int  m_cyc = 0;   // clock edges seen
    int  m_cnt = 0;

    function automatic void model_opd(input logic [4:0] rs, input logic [XLEN-1:0] regd,
                                      output logic [XLEN-1:0] val, output bit nr);
        val = regd;
        nr  = 0;
        if (rs == 5'd0) return;
        foreach (hist[j]) begin
            int age;
            age = m_cyc - hist[j].cyc - 1;
            if (age < DEPTH && hist[j].rd == rs) begin
                if (hist[j].ld && age < LOAD_LAT) nr = 1;
                else val = stg[age*XLEN +: XLEN];
                return;
            end
        end
    endfunction

    function automatic void model_eval(output bit s, output logic [XLEN-1:0] v1,
                                       output logic [XLEN-1:0] v2);
        bit nr1, nr2;
        model_opd(ID_rs1, regs1, v1, nr1);
        model_opd(ID_rs2, regs2, v2, nr2);
        s = ID_vld && !flush && ((ID_rs1_used && nr1) || (ID_rs2_used && nr2));
    endfunction

    // Model state update on each clock edge, from the inputs held across it.
    initial forever begin
        bit s;
        logic [XLEN-1:0] v1, v2;
        @(posedge clk);
        model_eval(s, v1, v2);
        if (rst) begin
            hist.delete();
            m_cnt = 0;
        end else begin
            if (s && m_cnt < CNT_MAX) m_cnt++;
            if (ID_vld && !s && !flush && ID_rd_vld && ID_rd != 5'd0)
                hist.push_front('{cyc: m_cyc, rd: ID_rd, ld: ID_is_load});
        end
        m_cyc++;
        while (hist.size() > 0 && (m_cyc - hist[hist.size()-1].cyc - 1) >= DEPTH)
            void'(hist.pop_back());
    end

    // ---------------- scoreboard / compare ----------------
    logic [66:0] exp_q[$];   // {stall, cnt[1:0], rs1, rs2}

    initial forever begin
        bit s;
        logic [XLEN-1:0] v1, v2;
        logic [66:0] e;
        @(negedge clk);
        if (chk_en) begin
            model_eval(s, v1, v2);
            exp_q.push_back({s, 2'(m_cnt), v1, v2});
            e = exp_q.pop_front();
            chk("sb_stall", 32'(of_stall), 32'(e[66]));
            chk("sb_cnt", 32'(of_cnt), 32'(e[65:64]));
            if (!e[66]) begin
                chk("sb_rs1", of_rs1, e[63:32]);
                chk("sb_rs2", of_rs2, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        ID_vld = 0; ID_rd_vld = 0; ID_rd = 0; ID_is_load = 0;
        ID_rs1 = 0; ID_rs2 = 0; ID_rs1_used = 0; ID_rs2_used = 0; flush = 0;
    endtask

    task automatic idle_cycle();
        id_idle();
        settle();
        adv();
    endtask

    // One instruction writing rd leaves ID (reads nothing, so it never stalls).
    task automatic issue(input logic [4:0] rd, input bit ld);
        id_idle();
        ID_vld = 1; ID_rd_vld = 1; ID_rd = rd; ID_is_load = ld;
        settle();
        adv();
    endtask

    // Put a reading, non-writing instruction into ID (no clock advance).
    task automatic read(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2);
        id_idle();
        ID_vld = 1;
        ID_rs1 = rs1; ID_rs1_used = u1;
        ID_rs2 = rs2; ID_rs2_used = u2;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        rst = 1; id_idle(); stg = STG_DEF; regs1 = REGS1; regs2 = REGS2;
        adv();
        chk_en = 1;
        adv();
        // Reset state
        settle();
        chk("rst_stall", 32'(of_stall), 32'd0);
        chk("rst_cnt", 32'(of_cnt), 32'd0);
        chk("rst_rs1", of_rs1, REGS1);
        chk("rst_rs2", of_rs2, REGS2);
        adv();
        rst = 0;

        // 1: ALU back-to-back forwards from EX
        issue(5'd5, 0);
        read(5'd5, 1, 5'd6, 1);
        settle();
        chk("alu_rs1", of_rs1, 32'hA000_0000);
        chk("alu_rs2", of_rs2, REGS2);
        chk("alu_stall", 32'(of_stall), 32'd0);
        adv();

        // 2: youngest of two matches wins (entry0 over entry2)
        issue(5'd5, 0);
        idle_cycle();
        issue(5'd5, 0);
        stg = {32'h22, 32'h33, 32'h11};
        read(5'd0, 1, 5'd5, 1);
        settle();
        chk("prio_rs2", of_rs2, 32'h11);
        chk("prio_x0_rs1", of_rs1, REGS1);
        adv();
        stg = STG_DEF;
        idle_cycle();
        idle_cycle();

        // 3: load-use, one stall then forward from MEM
        issue(5'd7, 1);
        read(5'd7, 1, 5'd0, 0);
        settle();
        chk("lu_stall", 32'(of_stall), 32'd1);
        chk("lu_cnt0", 32'(of_cnt), 32'd0);
        adv();
        settle();
        chk("lu_stall2", 32'(of_stall), 32'd0);
        chk("lu_cnt1", 32'(of_cnt), 32'd1);
        chk("lu_rs1", of_rs1, 32'hB000_0001);
        adv();
        idle_cycle();
        idle_cycle();

        // 4: unused operand never stalls
        issue(5'd7, 1);
        read(5'd3, 1, 5'd7, 0);
        settle();
        chk("unused_stall", 32'(of_stall), 32'd0);
        adv();
        idle_cycle();
        idle_cycle();

        // 5a: writer of x0 is never forwarded
        issue(5'd0, 0);
        read(5'd0, 1, 5'd0, 1);
        settle();
        chk("x0_rs1", of_rs1, REGS1);
        chk("x0_rs2", of_rs2, REGS2);
        adv();
        idle_cycle();
        idle_cycle();

        // 5b: flush beats load-use stall, flushed writer becomes a bubble
        issue(5'd7, 1);
        read(5'd7, 1, 5'd0, 0);
        ID_rd_vld = 1; ID_rd = 5'd9; flush = 1;
        settle();
        chk("flush_stall", 32'(of_stall), 32'd0);
        adv();
        read(5'd9, 1, 5'd7, 1);
        settle();
        chk("flush_bubble_rs1", of_rs1, REGS1);
        chk("flush_ld_rs2", of_rs2, 32'hB000_0001);
        chk("flush_stall2", 32'(of_stall), 32'd0);
        adv();
        idle_cycle();
        idle_cycle();

        // Older ready match must not mask a younger unready load
        issue(5'd12, 0);
        idle_cycle();
        issue(5'd12, 1);
        read(5'd12, 1, 5'd0, 0);
        settle();
        chk("mask_stall", 32'(of_stall), 32'd1);
        adv();
        settle();
        chk("mask_rs1", of_rs1, 32'hB000_0001);
        chk("mask_cnt", 32'(of_cnt), 32'd2);
        adv();
        idle_cycle();
        idle_cycle();

        // 6a: reset during a stall
        issue(5'd8, 1);
        read(5'd8, 1, 5'd0, 0);
        rst = 1;
        settle();
        chk("rststall_before", 32'(of_stall), 32'd1);
        adv();
        rst = 0;
        settle();
        chk("rststall_stall", 32'(of_stall), 32'd0);
        chk("rststall_cnt", 32'(of_cnt), 32'd0);
        chk("rststall_rs1", of_rs1, REGS1);
        adv();
        idle_cycle();

        // 6b: counter saturates at all-ones after 3 stalls
        for (int n = 1; n <= 4; n++) begin
            issue(5'd10, 1);
            read(5'd10, 1, 5'd0, 0);
            settle();
            adv();
            settle();
            chk("sat_cnt", 32'(of_cnt), (n < CNT_MAX) ? 32'(n) : 32'(CNT_MAX));
            adv();
        end
        idle_cycle();
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
